// File: rtl/uart_tx_stream_if.sv
// Byte-stream handshake plus serial line between the FIFO side and the UART
// transmitter. Handshake: a byte moves on a rising clk edge where i_en (valid,
// driven by the producer) and i_rdy (ready, driven by the transmitter) are both
// high; i_rdy never depends on i_en, and i_data is only looked at on that edge.
interface uart_tx_stream_if;
  logic       i_en;
  logic [7:0] i_data;
  logic       i_rdy;
  logic       o_tx;
  logic       o_busy;
  logic [2:0] o_state;

  modport master (
    output i_en, i_data,
    input  i_rdy, o_tx, o_busy, o_state
  );

  modport slave (
    input  i_en, i_data,
    output i_rdy, o_tx, o_busy, o_state
  );
endinterface

// File: rtl/uart_tx_stream.sv
// UART transmitter: pops one byte per frame from a valid/ready stream and sends
// start bit, 8 data bits LSB first, optional parity and 1 or 2 stop bits.
// o_state exposes the FSM state for debug visibility.
module uart_tx_stream #(
  parameter int CLK_DIV   = 434,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input logic            clk,
  input logic            rst,
  uart_tx_stream_if.slave bus
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);

  // Refuse to elaborate with unsupported parameter values.
  if (CLK_DIV < 2 || PARITY < 0 || PARITY > 2 || (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_bad_params
    $error("uart_tx_stream: illegal CLK_DIV/PARITY/STOP_BITS");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic            stop_q, stop_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_q, par_d;
  logic            tx_q, tx_d;
  logic            rdy;
  logic            busy;
  logic            tick;
  logic            accept;

  assign tick   = (cnt_q == CNT_LAST);
  assign accept = bus.i_en & rdy;

  // State register and registered datapath (o_tx is a flop, mark on reset).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

  // Next state: advance one bit every CLK_DIV cycles; the line value for the
  // next bit is decided on the same edge the state changes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    if (state_q != S_IDLE) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
    unique case (state_q)
      S_IDLE: begin
        tx_d  = 1'b1;
        cnt_d = '0;
        if (accept) begin
          state_d = S_START;
          tx_d    = 1'b0;
          shift_d = bus.i_data;
          par_d   = (PARITY == 1) ? ~^bus.i_data : ^bus.i_data;
          bit_d   = '0;
          stop_d  = 1'b0;
        end
      end
      S_START: begin
        if (tick) begin
          state_d = S_DATA;
          tx_d    = shift_q[0];
        end
      end
      S_DATA: begin
        if (tick) begin
          bit_d   = bit_q + 3'd1;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            if (PARITY != 0) begin
              state_d = S_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            tx_d = shift_q[1];
          end
        end
      end
      S_PARITY: begin
        if (tick) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
      end
      S_STOP: begin
        tx_d = 1'b1;
        if (tick) begin
          if (stop_q == STOP_LAST) begin
            state_d = S_IDLE;
            stop_d  = 1'b0;
          end else begin
            stop_d = ~stop_q;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // Outputs decoded from the state register; ready is forced low during reset.
  always_comb begin
    rdy  = (state_q == S_IDLE) && !rst;
    busy = (state_q != S_IDLE);
  end

  assign bus.i_rdy   = rdy;
  assign bus.o_busy  = busy;
  assign bus.o_tx    = tx_q;
  assign bus.o_state = state_q;

endmodule

// File: tb/tb_uart_tx_stream.sv
// Bench for uart_tx_stream: four instances covering no/odd/even parity and two
// stop bits, all at CLK_DIV=4, checked cycle by cycle against a frame model.
module tb_uart_tx_stream;

  localparam int CLKD = 4;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       en_r [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
  logic [7:0] data_r = 8'h00;

  int par_cfg  [4] = '{0, 1, 2, 0};
  int stop_cfg [4] = '{1, 1, 1, 2};

  uart_tx_stream_if if0 ();
  uart_tx_stream_if if1 ();
  uart_tx_stream_if if2 ();
  uart_tx_stream_if if3 ();

  assign if0.i_en = en_r[0];
  assign if1.i_en = en_r[1];
  assign if2.i_en = en_r[2];
  assign if3.i_en = en_r[3];
  assign if0.i_data = data_r;
  assign if1.i_data = data_r;
  assign if2.i_data = data_r;
  assign if3.i_data = data_r;

  uart_tx_stream #(.CLK_DIV(CLKD), .PARITY(0), .STOP_BITS(1)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  uart_tx_stream #(.CLK_DIV(CLKD), .PARITY(1), .STOP_BITS(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  uart_tx_stream #(.CLK_DIV(CLKD), .PARITY(2), .STOP_BITS(1)) dut2 (.clk(clk), .rst(rst), .bus(if2));
  uart_tx_stream #(.CLK_DIV(CLKD), .PARITY(0), .STOP_BITS(2)) dut3 (.clk(clk), .rst(rst), .bus(if3));

  int tests_run    = 0;
  int tests_failed = 0;

  // Scoreboard: expected {tx, rdy, busy} per cycle, and bytes still to offer.
  logic [2:0] exp_q  [$];
  logic [7:0] pend_q [$];

  function automatic logic [2:0] obs(input int k);
    logic [2:0] r;
    r = 3'b000;
    case (k)
      0: r = {if0.o_tx, if0.i_rdy, if0.o_busy};
      1: r = {if1.o_tx, if1.i_rdy, if1.o_busy};
      2: r = {if2.o_tx, if2.i_rdy, if2.o_busy};
      3: r = {if3.o_tx, if3.i_rdy, if3.o_busy};
      default: r = 3'bxxx;
    endcase
    return r;
  endfunction

  // Reference model: list the frame's line bits, hold each CLK_DIV cycles,
  // then one idle/mark cycle where the next byte may be taken.
  function automatic void model_frame(input logic [7:0] b, input int k);
    logic bits [$];
    int   ones;
    ones = $countones(b);
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(b[i]);
    if (par_cfg[k] == 1) bits.push_back((ones % 2) == 0);
    else if (par_cfg[k] == 2) bits.push_back((ones % 2) == 1);
    for (int s = 0; s < stop_cfg[k]; s++) bits.push_back(1'b1);
    foreach (bits[j]) begin
      for (int c = 0; c < CLKD; c++) exp_q.push_back({bits[j], 1'b0, 1'b1});
    end
    exp_q.push_back(3'b110);
  endfunction

  // Driver: FIFO-like producer offering pend_q with i_en held while bytes
  // remain; i_data is randomised whenever nothing is offered.
  task automatic drive_offer(input int k);
    en_r[k] = (pend_q.size() > 0);
    data_r  = (pend_q.size() > 0) ? pend_q[0] : 8'($urandom_range(0, 255));
  endtask

  task automatic run_stream(input int k, input string name);
    int         n;
    int         bad;
    logic       will;
    logic [2:0] o;
    logic [2:0] e;
    logic [2:0] cur;
    bad = 0;
    exp_q.delete();
    foreach (pend_q[i]) model_frame(pend_q[i], k);
    n = exp_q.size();
    @(negedge clk);
    drive_offer(k);
    cur  = obs(k);
    will = en_r[k] && cur[1];
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      o = obs(k);
      e = exp_q.pop_front();
      tests_run++;
      if (o !== e) begin
        tests_failed++;
        if (bad < 5) $display("FAIL %s cycle %0d: tx/rdy/busy got %b expected %b", name, c, o, e);
        bad++;
      end
      if (will && pend_q.size() > 0) void'(pend_q.pop_front());
      drive_offer(k);
      will = en_r[k] && o[1];
    end
    en_r[k] = 1'b0;
    tests_run++;
    if (pend_q.size() != 0) begin
      tests_failed++;
      $display("FAIL %s drained: %0d bytes left, expected 0", name, pend_q.size());
    end
    pend_q.delete();
  endtask

  task automatic test_reset();
    logic [2:0] o;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      o = obs(k);
      tests_run++;
      if (o !== 3'b100) begin
        tests_failed++;
        $display("FAIL reset_state dut%0d: tx/rdy/busy got %b expected 100", k, o);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      o = obs(k);
      tests_run++;
      if (o !== 3'b110) begin
        tests_failed++;
        $display("FAIL reset_release dut%0d: tx/rdy/busy got %b expected 110", k, o);
      end
    end
  endtask

  task automatic test_basic();
    pend_q.push_back(8'h55);
    run_stream(0, "basic_55");
    for (int i = 0; i < 3; i++) begin
      pend_q.push_back(8'($urandom_range(0, 255)));
      run_stream(0, "basic_rand");
    end
  endtask

  task automatic test_parity();
    pend_q.push_back(8'hA5);
    run_stream(2, "parity_even_A5");
    pend_q.push_back(8'hA5);
    run_stream(1, "parity_odd_A5");
    pend_q.push_back(8'h01);
    run_stream(2, "parity_even_01");
    for (int i = 0; i < 3; i++) begin
      pend_q.push_back(8'($urandom_range(0, 255)));
      run_stream(1, "parity_odd_rand");
      pend_q.push_back(8'($urandom_range(0, 255)));
      run_stream(2, "parity_even_rand");
    end
  endtask

  task automatic test_two_stop();
    pend_q.push_back(8'hFF);
    run_stream(3, "two_stop_FF");
    pend_q.push_back(8'($urandom_range(0, 255)));
    run_stream(3, "two_stop_rand");
  endtask

  task automatic test_back_to_back();
    pend_q.push_back(8'h01);
    pend_q.push_back(8'h02);
    pend_q.push_back(8'h03);
    run_stream(0, "b2b_010203");
    for (int i = 0; i < 5; i++) pend_q.push_back(8'($urandom_range(0, 255)));
    run_stream(3, "b2b_two_stop_rand");
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 4; i++) pend_q.push_back(8'($urandom_range(0, 255)));
    run_stream(1, "backpressure_odd");
    for (int i = 0; i < 4; i++) pend_q.push_back(8'($urandom_range(0, 255)));
    run_stream(2, "backpressure_even");
  endtask

  task automatic test_reset_mid_frame();
    logic [2:0] o;
    int         bad;
    @(negedge clk);
    en_r[0] = 1'b1;
    data_r  = 8'h00;
    @(negedge clk);
    en_r[0] = 1'b0;
    // now at the first sample of the start bit; data bit 3 spans samples 16..19
    repeat (17) @(negedge clk);
    o = obs(0);
    tests_run++;
    if (o !== 3'b001) begin
      tests_failed++;
      $display("FAIL midframe_bit3: tx/rdy/busy got %b expected 001", o);
    end
    rst = 1'b1;
    @(negedge clk);
    o = obs(0);
    tests_run++;
    if (o !== 3'b100) begin
      tests_failed++;
      $display("FAIL midframe_in_reset: tx/rdy/busy got %b expected 100", o);
    end
    rst = 1'b0;
    #1;
    o = obs(0);
    tests_run++;
    if (o !== 3'b110) begin
      tests_failed++;
      $display("FAIL midframe_rdy_after_reset: tx/rdy/busy got %b expected 110", o);
    end
    bad = 0;
    repeat (3 * 10 * CLKD) begin
      @(negedge clk);
      o = obs(0);
      if (o !== 3'b110) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL midframe_no_retransmit: %0d non-idle cycles, expected 0", bad);
    end
    pend_q.push_back(8'h3C);
    run_stream(0, "after_reset_3C");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_two_stop();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/uart_tx_stream.md
Name: uart_tx_stream

Overview:
- Byte-stream UART transmitter sitting directly downstream of the sync FIFO in the NFC/heart-rate data path.
- Pops bytes from the FIFO over a valid/ready handshake and serialises each one onto a single TX line: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
- Feeds the host/debug UART link; provides backpressure by holding i_rdy low while a frame is in flight.

Parameters:
- CLK_DIV, 434, clock cycles per UART bit (50 MHz / 115200); legal range >= 2.
- PARITY, 0, 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- i_rdy  output  1  input-ready; high only when idle and rst low.
- i_en  input  1  input-valid from the FIFO (its o_en).
- i_data  input  8  byte to send (FIFO o_data).
- o_tx  output  1  UART serial line, idle/mark = 1.
- o_busy  output  1  high while a frame is in progress.

Behaviour:
- Clock/reset: one clock (clk); reset is synchronous and active-high (rst). While rst is high at a clock edge: state <= IDLE, o_tx <= 1, baud counter <= 0, bit index <= 0. o_busy = 0 and i_rdy = 0 throughout reset.
- i_rdy = (state == IDLE) & ~rst, combinational from the state register. o_busy = (state != IDLE), derived from the state register.
- Accept: a transfer occurs on an edge where i_en & i_rdy. On that edge:
  - i_data is latched into a shift register, and parity is computed from it.
  - state <= START, o_tx <= 0, counter <= 0.
  - Bytes are never taken without i_rdy. While busy, i_data and i_en are ignored.
- States: IDLE -> START -> DATA -> (PARITY if PARITY != 0) -> STOP -> IDLE.
- Bit timing:
  - Every bit holds o_tx stable for exactly CLK_DIV cycles.
  - The counter runs 0..CLK_DIV-1; at CLK_DIV-1 it wraps to 0 and the FSM advances.
  - o_tx is registered and changes on the same edge as the state.
- DATA: 8 bits, LSB first. The bit index runs 0..7 and the shift register shifts right on each bit boundary.
- PARITY: odd = ~^byte, even = ^byte, one bit period.
- STOP: o_tx = 1 for STOP_BITS*CLK_DIV cycles, then state <= IDLE.
- Frame length: CLK_DIV*(10 + (PARITY != 0) + (STOP_BITS - 1)) cycles from the accept edge to the edge where state returns to IDLE.
- Back-to-back: if i_en is held high, the next byte is accepted in the first IDLE cycle. This leaves exactly 1 clk of mark between the end of a stop bit and the next start bit. No bytes are dropped or reordered.
- Widths: counter is $clog2(CLK_DIV) bits; bit index is 3 bits; stop counter is 1 bit.
- Reset mid-frame:
  - The frame is abandoned and o_tx = 1 from the edge rst is sampled.
  - The partially sent byte is not retransmitted.
  - i_rdy returns high the first cycle rst is low.
- Illegal parameters (CLK_DIV < 2, PARITY > 2, STOP_BITS not 1 or 2) are not supported. An elaboration-time check is required.

Test Plan:
- Basic frame, CLK_DIV=4, PARITY=0, STOP_BITS=1: send 0x55 -> o_tx = 0,1,0,1,0,1,0,1,0,1, each bit held 4 clks. i_rdy low for exactly 40 clks after the accept edge; o_busy high for the same 40 clks.
- Parity, CLK_DIV=4: 0xA5 with PARITY=2 -> parity bit 0. 0xA5 with PARITY=1 -> parity bit 1. 0x01 with PARITY=2 -> parity bit 1. Frame length 44 clks.
- Two stop bits, CLK_DIV=4, PARITY=0, STOP_BITS=2: 0xFF -> start 0, then o_tx high for 8 data + 2 stop bits = 40 clks. Frame length 44 clks.
- Connected to the FIFO, CLK_DIV=4: write 0x01, 0x02, 0x03 -> three frames in order. Exactly 1 clk of mark between frames; FIFO drains to empty; i_data changes mid-frame have no effect.
- Reset mid-frame: assert rst for 1 clk during data bit 3 of 0x00 -> o_tx = 1 from the next edge and i_rdy = 0 during rst. The next byte, 0x3C, is transmitted completely and correctly.
- Backpressure: i_en held high with a byte while busy -> no accept until IDLE. The byte is sent once, and its frame starts exactly 1 clk after the previous frame's stop bit ends.
